// File: rtl/mdio_master_22_45.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_master_22_45
//  Purpose  : MDIO station-management initiator. Derives MDC from clk_25m and
//             serialises one Clause 22 / Clause 45 frame per accepted request
//             (PRE, ST, OP, PHYAD, REGAD/DEVAD, TA, DATA). Read data and a
//             turnaround error flag return on a one-cycle response strobe.
//  Ports    : clk_25m, rst_n           - clock, async active-low reset
//             enable, preamble_en,
//             opendrain_mode           - static controls
//             req_*                    - request port (valid/ready)
//             busy, resp_*             - status and response strobe
//             mdc, mdio_out, mdio_oe,
//             mdio_in                  - MDIO pad interface
//  Revision : 1.0 - initial release
// ============================================================================
module mdio_master_22_45 #(
   parameter int MDC_HALF = 5,   // clk_25m cycles per MDC half-period, >= 2
   parameter int PRE_LEN  = 32   // preamble length in bits, 1..64
) (
   input  logic        clk_25m,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        preamble_en,
   input  logic        opendrain_mode,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_st,
   input  logic [1:0]  req_op,
   input  logic [4:0]  req_phyad,
   input  logic [4:0]  req_regad,
   input  logic [15:0] req_wdata,
   output logic        busy,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        mdc,
   output logic        mdio_out,
   output logic        mdio_oe,
   input  logic        mdio_in
);

   localparam int              PH_W     = $clog2(2 * MDC_HALF);
   localparam logic [PH_W-1:0] PH_RISE  = PH_W'(MDC_HALF);
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * MDC_HALF - 1);
   localparam logic [5:0]      PRE_LAST = 6'(PRE_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_HDR  = 3'd2,
      S_TA   = 3'd3,
      S_DATA = 3'd4,
      S_END  = 3'd5
   } state_t;

   state_t          state_q, state_d, next_state;
   logic [PH_W-1:0] ph_q, ph_d;
   logic [5:0]      bit_q, bit_d, bit_last;
   logic [13:0]     hdr_q, hdr_d;
   logic [15:0]     wdata_q, wdata_d;
   logic            rd_q, rd_d;
   logic [15:0]     shift_q, shift_d;
   logic            err_cap_q, err_cap_d;
   logic [1:0]      sync_q, sync_d;
   logic            mdc_q, mdc_d;
   logic            out_q, out_d;
   logic            mdio_oe_q, mdio_oe_d;
   logic            req_ready_q, req_ready_d;
   logic            busy_q, busy_d;
   logic            resp_valid_q, resp_valid_d;
   logic [15:0]     resp_rdata_q, resp_rdata_d;
   logic            resp_err_q, resp_err_d;
   logic            bit_val, bit_oe, oe_int;

   // State register
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         ph_q         <= '0;
         bit_q        <= '0;
         hdr_q        <= '0;
         wdata_q      <= '0;
         rd_q         <= 1'b0;
         shift_q      <= '0;
         err_cap_q    <= 1'b0;
         sync_q       <= 2'b11;
         mdc_q        <= 1'b0;
         out_q        <= 1'b1;
         mdio_oe_q    <= 1'b0;
         req_ready_q  <= 1'b0;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         ph_q         <= ph_d;
         bit_q        <= bit_d;
         hdr_q        <= hdr_d;
         wdata_q      <= wdata_d;
         rd_q         <= rd_d;
         shift_q      <= shift_d;
         err_cap_q    <= err_cap_d;
         sync_q       <= sync_d;
         mdc_q        <= mdc_d;
         out_q        <= out_d;
         mdio_oe_q    <= mdio_oe_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Pad outputs are computed from the current state and registered, so the
   // pins lag the FSM by one cycle. mdio_in is sampled on the same cycle the
   // registered MDC goes high, keeping capture aligned to the pin edge.
   always_comb begin
      state_d      = state_q;
      ph_d         = ph_q;
      bit_d        = bit_q;
      hdr_d        = hdr_q;
      wdata_d      = wdata_q;
      rd_d         = rd_q;
      shift_d      = shift_q;
      err_cap_d    = err_cap_q;
      sync_d       = {sync_q[0], mdio_in};
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mdc_d        = 1'b0;
      out_d        = 1'b1;
      oe_int       = 1'b0;
      bit_val      = 1'b1;
      bit_oe       = 1'b0;
      bit_last     = 6'd0;
      next_state   = S_IDLE;

      // Per-state bit source and field length
      case (state_q)
         S_PRE: begin
            bit_val    = 1'b1;
            bit_oe     = 1'b1;
            bit_last   = PRE_LAST;
            next_state = S_HDR;
         end
         S_HDR: begin
            bit_val    = hdr_q[4'd13 - bit_q[3:0]];
            bit_oe     = 1'b1;
            bit_last   = 6'd13;
            next_state = S_TA;
         end
         S_TA: begin
            // Write-type turnaround drives "10"; reads release the line
            bit_val    = rd_q ? 1'b1 : (bit_q == 6'd0);
            bit_oe     = ~rd_q;
            bit_last   = 6'd1;
            next_state = S_DATA;
         end
         S_DATA: begin
            bit_val    = rd_q ? 1'b1 : wdata_q[4'd15 - bit_q[3:0]];
            bit_oe     = ~rd_q;
            bit_last   = 6'd15;
            next_state = S_END;
         end
         default: ;
      endcase

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q && enable) begin
               hdr_d     = {req_st, req_op, req_phyad, req_regad};
               wdata_d   = req_wdata;
               rd_d      = ((req_st == 2'b01) && (req_op == 2'b10)) ||
                           ((req_st == 2'b00) && req_op[1]);
               shift_d   = '0;
               err_cap_d = 1'b0;
               ph_d      = '0;
               bit_d     = '0;
               state_d   = preamble_en ? S_PRE : S_HDR;
            end
         end
         S_PRE, S_HDR, S_TA, S_DATA: begin
            mdc_d  = (ph_q >= PH_RISE);
            out_d  = bit_val;
            oe_int = bit_oe;
            if (ph_q == PH_RISE) begin
               if (rd_q && (state_q == S_TA) && (bit_q == 6'd1)) begin
                  err_cap_d = sync_q[1];
               end
               if (rd_q && (state_q == S_DATA)) begin
                  shift_d = {shift_q[14:0], sync_q[1]};
               end
            end
            if (ph_q == PH_LAST) begin
               ph_d = '0;
               if (bit_q == bit_last) begin
                  bit_d   = '0;
                  state_d = next_state;
               end else begin
                  bit_d = bit_q + 6'd1;
               end
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         S_END: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = rd_q ? shift_q : 16'h0000;
            resp_err_d   = rd_q & err_cap_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Disable aborts the frame with no response
      if (!enable) begin
         state_d      = S_IDLE;
         resp_valid_d = 1'b0;
         resp_rdata_d = resp_rdata_q;
         resp_err_d   = resp_err_q;
         mdc_d        = 1'b0;
         out_d        = 1'b1;
         oe_int       = 1'b0;
      end

      req_ready_d = enable && (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      mdio_oe_d   = opendrain_mode ? (oe_int & ~out_d) : oe_int;
   end

   assign req_ready  = req_ready_q;
   assign busy       = busy_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mdc        = mdc_q;
   assign mdio_out   = out_q;
   assign mdio_oe    = mdio_oe_q;

endmodule
`default_nettype wire
